note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Playback end of the note recorder: reads back the 16-entry note memory (6-bit words, {octave[1:0], note[3:0]}) in address order and plays each note as a square wave on a single audio pin.
- Drives the memory read address and presents the latched note to the existing frequency lookup.
- Takes the lookup's half-period count back and times tone, note duration and inter-note gap.
- Sits between the recording datapath's memory/frequency-select and the audio output pin.

Parameters:
- NOTE_TICKS, 25000000: clk cycles each note is sounded (0.5 s at 50 MHz); must be >=1.
- GAP_TICKS, 1250000: clk cycles of silence after each note; 0 means no gap state.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begin playback from address 0 (honoured only in IDLE)
- stop  in  1  abort playback; highest priority after reset
- note_count  in  5  number of recorded notes, 0..16; values >16 clamp to 16; sampled on accepted start
- rd_addr  out  4  memory read address
- rd_data  in  6  memory q; valid one cycle after rd_addr is presented
- cur_note  out  6  latched {octave,note} fed to frequency lookup
- half_period  in  32  clk cycles per audio half-period for cur_note (combinational from lookup)
- audio_out  out  1  square-wave output
- playing  out  1  high in FETCH/LATCH/PLAY/GAP
- done  out  1  one-cycle pulse when last note's gap (or note, if GAP_TICKS=0) completes

Behaviour:
- Reset (reset==0 at posedge): state=IDLE; rd_addr=0, cur_note=0, audio_out=0, playing=0, done=0; all counters 0.
- States: IDLE, FETCH, LATCH, PLAY, GAP.
- IDLE: audio_out=0. start=1 with clamped note_count!=0 -> store count, rd_addr<=0, go FETCH. start with note_count==0 is ignored; stay IDLE, no done.
- FETCH: exactly 1 cycle; memory samples rd_addr. Next state LATCH.
- LATCH: exactly 1 cycle; cur_note<=rd_data at end of cycle; clear tone and duration counters, audio_out<=0; go PLAY.
- PLAY: exactly NOTE_TICKS cycles.
  - Tone counter increments each cycle. When it reaches half_period-1: toggle audio_out, counter<=0.
  - If half_period==0 or cur_note[3:0]==4'hF (rest): audio_out held 0.
  - At end: audio_out<=0; go GAP, or if GAP_TICKS==0 go directly to advance.
- GAP: exactly GAP_TICKS cycles, audio_out=0, then advance.
- Advance:
  - If rd_addr==stored_count-1: done=1 for one cycle, go IDLE, rd_addr<=0.
  - Else rd_addr<=rd_addr+1, go FETCH.
  - rd_addr is 4-bit: 16 notes end at address 15 with no wrap beyond.
- Per-note latency from advance to first sounding cycle: FETCH+LATCH = 2 cycles.
- stop=1 in any state: next edge state=IDLE, audio_out=0, playing=0, rd_addr=0, no done pulse. stop and start in the same cycle: stop wins.
- start while not IDLE: ignored.
- note_count changes after start: no effect until the next accepted start.
- reset low mid-note: immediate return to reset values at that edge.
- Counters are 32-bit. Tone compare uses the full half_period width. Duration counter sized for NOTE_TICKS/GAP_TICKS.

Optional Feature:
- Macro LOOP_PLAYBACK_EN.
- Defined: at advance from the last note, no done pulse and no return to IDLE; rd_addr<=0, go FETCH and replay indefinitely until stop or reset. done never asserts.
- Undefined: single pass as above, done pulse at end.

Test Plan:
- Reset: NOTE_TICKS=8, GAP_TICKS=2. Hold reset low 3 cycles -> all outputs 0, state IDLE; start pulse while reset low -> ignored.
- Memory {0x05,0x16,0x2F}, note_count=3, half_period=2, start pulse:
  - rd_addr sequence 0,1,2; cur_note 0x05,0x16,0x2F, each valid 2 cycles after its address.
  - audio_out toggles every 2 cycles during the 8 PLAY cycles of each non-rest note.
  - Third note (rest) gives audio_out=0 throughout.
  - done pulses once exactly 3*(2+8+2) cycles after start; playing low afterwards.
- note_count=16, memory filled: rd_addr 0..15 each once, done after 16*12 cycles, rd_addr back to 0. note_count=20 gives the same result (clamp).
- Assert stop during second note's PLAY -> next cycle IDLE, audio_out=0, playing=0, no done. Start in same cycle as stop -> stays IDLE.
- note_count=0 with start -> stays IDLE, playing never high, no done. half_period=0 on a non-rest note -> audio_out stays 0 for that note.
- LOOP_PLAYBACK_EN defined, note_count=2: rd_addr sequence 0,1,0,1,0 over 5 notes with no done pulse; stop ends playback.

Source files
------------

// File: rtl/note_player.sv
// note_player: plays back the recorded note memory in address order as a
// square wave on audio_out. Each note is fetched (FETCH), latched into
// cur_note for the frequency lookup (LATCH), sounded for NOTE_TICKS cycles
// (PLAY) and followed by GAP_TICKS cycles of silence (GAP).
// Optional build macro LOOP_PLAYBACK_EN: replay the recording indefinitely
// until stop or reset instead of finishing with a done pulse.
module note_player #(
  parameter int unsigned NOTE_TICKS = 25000000,
  parameter int unsigned GAP_TICKS  = 1250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  note_count,
  output logic [3:0]  rd_addr,
  input  logic [5:0]  rd_data,
  output logic [5:0]  cur_note,
  input  logic [31:0] half_period,
  output logic        audio_out,
  output logic        playing,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, FETCH, LATCH, PLAY, GAP} state_t;

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_TICKS - 1);
  localparam logic [31:0] GAP_LAST  = (GAP_TICKS == 0) ? 32'd0 : 32'(GAP_TICKS - 1);
  localparam bit          HAS_GAP   = (GAP_TICKS != 0);
`ifdef LOOP_PLAYBACK_EN
  localparam bit          LOOP      = 1'b1;
`else
  localparam bit          LOOP      = 1'b0;
`endif

  state_t      state;
  state_t      state_next;
  logic [4:0]  count_reg;
  logic [4:0]  clamped;
  logic [31:0] tone_cnt;
  logic [31:0] dur_cnt;
  logic        dur_end;
  logic        advance;
  logic        last_note;
  logic        silent;

  // More than 16 notes cannot exist in a 16-entry memory.
  assign clamped   = (note_count > 5'd16) ? 5'd16 : note_count;
  assign last_note = ({1'b0, rd_addr} == count_reg - 5'd1);
  // A rest (note nibble F) or an unknown frequency (half_period 0) stays silent.
  assign silent    = (half_period == 32'd0) || (cur_note[3:0] == 4'hF);
  assign playing   = (state != IDLE);
  assign dur_end   = (state == PLAY) ? (dur_cnt == NOTE_LAST)
                                     : ((state == GAP) && (dur_cnt == GAP_LAST));

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; stop overrides everything except reset.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    if (stop) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (start && (clamped != 5'd0)) state_next = FETCH;
        FETCH:   state_next = LATCH;
        LATCH:   state_next = PLAY;
        PLAY: begin
          if (dur_end) begin
            if (HAS_GAP) state_next = GAP;
            else         advance    = 1'b1;
          end
        end
        GAP:     if (dur_end) advance = 1'b1;
        default: state_next = IDLE;
      endcase
      if (advance) state_next = (last_note && !LOOP) ? IDLE : FETCH;
    end
  end

  // Address, note latch, tone/duration counters and the audio square wave.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_addr   <= 4'd0;
      cur_note  <= 6'd0;
      audio_out <= 1'b0;
      done      <= 1'b0;
      count_reg <= 5'd0;
      tone_cnt  <= 32'd0;
      dur_cnt   <= 32'd0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        rd_addr   <= 4'd0;
        audio_out <= 1'b0;
        tone_cnt  <= 32'd0;
        dur_cnt   <= 32'd0;
      end else begin
        case (state)
          IDLE: begin
            audio_out <= 1'b0;
            if (start && (clamped != 5'd0)) begin
              count_reg <= clamped;
              rd_addr   <= 4'd0;
              tone_cnt  <= 32'd0;
              dur_cnt   <= 32'd0;
            end
          end
          LATCH: begin
            cur_note  <= rd_data;
            tone_cnt  <= 32'd0;
            dur_cnt   <= 32'd0;
            audio_out <= 1'b0;
          end
          PLAY: begin
            if (dur_end) begin
              audio_out <= 1'b0;
              tone_cnt  <= 32'd0;
              dur_cnt   <= 32'd0;
            end else begin
              dur_cnt <= dur_cnt + 32'd1;
              if (silent) begin
                audio_out <= 1'b0;
                tone_cnt  <= 32'd0;
              end else if (tone_cnt >= half_period - 32'd1) begin
                // >= rather than == so a lookup change mid-note cannot strand the counter.
                audio_out <= ~audio_out;
                tone_cnt  <= 32'd0;
              end else begin
                tone_cnt <= tone_cnt + 32'd1;
              end
            end
          end
          GAP: begin
            audio_out <= 1'b0;
            dur_cnt   <= dur_end ? 32'd0 : dur_cnt + 32'd1;
          end
          default: ;
        endcase
        if (advance) begin
          if (last_note) begin
            rd_addr <= 4'd0;
            done    <= ~LOOP;
          end else begin
            rd_addr <= rd_addr + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Testbench for note_player with NOTE_TICKS=8, GAP_TICKS=2. A synchronous
// memory model feeds rd_data; expected per-cycle behaviour is built from the
// playback timeline (2 setup cycles, 8 play cycles, 2 gap cycles per note).
module tb_note_player;
  localparam int NT = 8;
  localparam int GT = 2;
  localparam int PER_NOTE = 2 + NT + GT;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [4:0]  note_count;
  logic [3:0]  rd_addr;
  logic [5:0]  rd_data;
  logic [5:0]  cur_note;
  logic [31:0] half_period;
  logic        audio_out, playing, done;
  logic [5:0]  mem [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] addr;
    logic [5:0] note;
    bit         note_chk;
    logic       audio;
    logic       play;
    logic       done;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) rd_data <= mem[rd_addr];

  note_player #(.NOTE_TICKS(NT), .GAP_TICKS(GT)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .note_count(note_count), .rd_addr(rd_addr), .rd_data(rd_data),
    .cur_note(cur_note), .half_period(half_period), .audio_out(audio_out),
    .playing(playing), .done(done)
  );

  // Timeline of observable outputs for one playback, cycle 0 = first FETCH.
  function automatic void build_expected(input int count, input int notes, input int hp, input bit loop_mode);
    exp_t e;
    int   i;
    bit   rest;
    exp_q.delete();
    for (int j = 0; j < notes; j++) begin
      i = j % count;
      rest = (mem[i][3:0] == 4'hF) || (hp == 0);
      e.addr = 4'(i); e.play = 1'b1; e.done = 1'b0; e.audio = 1'b0;
      e.note = 6'd0; e.note_chk = 1'b0;
      exp_q.push_back(e);
      exp_q.push_back(e);
      e.note = mem[i]; e.note_chk = 1'b1;
      for (int k = 0; k < NT; k++) begin
        e.audio = rest ? 1'b0 : (((k / hp) % 2) == 1);
        exp_q.push_back(e);
      end
      e.audio = 1'b0;
      for (int g = 0; g < GT; g++) exp_q.push_back(e);
    end
    if (!loop_mode) begin
      e.addr = 4'd0; e.play = 1'b0; e.audio = 1'b0; e.done = 1'b1;
      e.note = mem[(notes - 1) % count]; e.note_chk = 1'b1;
      exp_q.push_back(e);
      e.done = 1'b0;
      for (int t = 0; t < 4; t++) exp_q.push_back(e);
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; stop = 1'b0; note_count = 5'd3; half_period = 32'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({rd_addr, cur_note, audio_out, playing, done} !== 13'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: addr=%0h note=%0h audio=%b playing=%b done=%b, required all 0",
                 c, rd_addr, cur_note, audio_out, playing, done);
      end
    end
    reset = 1'b1; start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_start_ignored cycle %0d: playing=%b done=%b, required 0 0", c, playing, done);
      end
    end
  endtask

  task automatic test_playback(input string name, input int nc, input int hp, input int notes,
                               input bit loop_mode, input bit perturb);
    int count;
    int term_idx;
    count = (nc > 16) ? 16 : nc;
    term_idx = notes * PER_NOTE;
    half_period = 32'(hp);
    build_expected(count, notes, hp, loop_mode);
    @(negedge clk);
    note_count = 5'(nc); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < exp_q.size(); c++) begin
      @(negedge clk);
      checks++;
      if (rd_addr !== exp_q[c].addr) begin
        errors++;
        $display("FAIL %s rd_addr cycle %0d: got %0d, required %0d", name, c, rd_addr, exp_q[c].addr);
      end
      checks++;
      if (audio_out !== exp_q[c].audio) begin
        errors++;
        $display("FAIL %s audio_out cycle %0d: got %b, required %b", name, c, audio_out, exp_q[c].audio);
      end
      checks++;
      if (playing !== exp_q[c].play) begin
        errors++;
        $display("FAIL %s playing cycle %0d: got %b, required %b", name, c, playing, exp_q[c].play);
      end
      checks++;
      if (done !== exp_q[c].done) begin
        errors++;
        $display("FAIL %s done cycle %0d: got %b, required %b", name, c, done, exp_q[c].done);
      end
      if (exp_q[c].note_chk) begin
        checks++;
        if (cur_note !== exp_q[c].note) begin
          errors++;
          $display("FAIL %s cur_note cycle %0d: got %0h, required %0h", name, c, cur_note, exp_q[c].note);
        end
      end
      // Start pulses and count changes while busy must be ignored.
      if (perturb && c < term_idx) begin
        start = ($urandom_range(0, 5) == 0);
        note_count = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_stop();
    mem[0] = 6'h05; mem[1] = 6'h16; mem[2] = 6'h2F;
    half_period = 32'd2;
    @(negedge clk);
    note_count = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(negedge clk);
    checks++;
    if (playing !== 1'b1 || rd_addr !== 4'd1) begin
      errors++;
      $display("FAIL stop_precondition: playing=%b addr=%0d, required 1 1", playing, rd_addr);
    end
    stop = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if ({playing, audio_out, rd_addr, done} !== 7'd0) begin
      errors++;
      $display("FAIL stop_abort: playing=%b audio=%b addr=%0d done=%b, required all 0",
               playing, audio_out, rd_addr, done);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0 || done !== 1'b0 || audio_out !== 1'b0) begin
        errors++;
        $display("FAIL stop_idle cycle %0d: playing=%b done=%b audio=%b, required 0 0 0", c, playing, done, audio_out);
      end
    end
    // stop and start together while idle: stop wins.
    note_count = 5'd3; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0) begin
        errors++;
        $display("FAIL stop_start_same_cycle cycle %0d: playing=%b, required 0", c, playing);
      end
    end
  endtask

  task automatic test_zero_count();
    @(negedge clk);
    note_count = 5'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL zero_count cycle %0d: playing=%b done=%b, required 0 0", c, playing, done);
      end
    end
  endtask

  task automatic test_reset_mid_note();
    mem[0] = 6'h05; mem[1] = 6'h16; mem[2] = 6'h2F;
    half_period = 32'd2;
    @(negedge clk);
    note_count = 5'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rd_addr, cur_note, audio_out, playing, done} !== 13'd0) begin
      errors++;
      $display("FAIL reset_mid_note: addr=%0h note=%0h audio=%b playing=%b done=%b, required all 0",
               rd_addr, cur_note, audio_out, playing, done);
    end
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_note_idle cycle %0d: playing=%b done=%b, required 0 0", c, playing, done);
      end
    end
  endtask

`ifdef LOOP_PLAYBACK_EN
  task automatic test_loop();
    mem[0] = 6'h12; mem[1] = 6'h27;
    test_playback("loop", 2, 2, 5, 1'b1, 1'b0);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    @(negedge clk);
    checks++;
    if ({playing, audio_out, rd_addr, done} !== 7'd0) begin
      errors++;
      $display("FAIL loop_stop: playing=%b audio=%b addr=%0d done=%b, required all 0",
               playing, audio_out, rd_addr, done);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (playing !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL loop_idle cycle %0d: playing=%b done=%b, required 0 0", c, playing, done);
      end
    end
  endtask
`else
  task automatic test_single_pass();
    mem[0] = 6'h05; mem[1] = 6'h16; mem[2] = 6'h2F;
    test_playback("three_notes", 3, 2, 3, 1'b0, 1'b0);
  endtask

  task automatic test_full_memory();
    for (int i = 0; i < 16; i++) mem[i] = 6'($urandom);
    test_playback("sixteen_notes", 16, 3, 16, 1'b0, 1'b0);
    test_playback("clamp_twenty", 20, 3, 16, 1'b0, 1'b0);
  endtask

  task automatic test_half_period_zero();
    mem[0] = 6'h13; mem[1] = 6'h24;
    test_playback("half_period_zero", 2, 0, 2, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int nc;
    int hp;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) mem[i] = 6'($urandom);
      nc = $urandom_range(1, 20);
      hp = $urandom_range(1, 4);
      test_playback("random", nc, hp, (nc > 16) ? 16 : nc, 1'b0, 1'b1);
    end
  endtask
`endif

  initial begin
    foreach (mem[i]) mem[i] = 6'd0;
    reset = 1'b0; start = 1'b0; stop = 1'b0; note_count = 5'd0; half_period = 32'd2;
    test_reset();
    test_stop();
    test_zero_count();
    test_reset_mid_note();
`ifdef LOOP_PLAYBACK_EN
    test_loop();
`else
    test_single_pass();
    test_full_memory();
    test_half_period_zero();
    test_random();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
